// File: rtl/sprite_anim_display.sv
// Purpose : draws a scaled, animated ROM sprite that slides up from START_Y to END_Y and then parks there, cycling its frames.
// Latency : xg/yg -> rgb/on is 1+ROM_LATENCY cycles, one pixel per cycle.
// Backpressure : none; the pixel path never stalls, and rom_data must return a fixed ROM_LATENCY cycles after rom_addr.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_xg, i_yg              current scan pixel coordinates
//   i_frame_tick            one-cycle pulse per video frame (drives motion and animation)
//   i_start                 one-cycle pulse; restarts the slide-in from START_Y
//   o_rom_addr              registered texel address (0 outside the sprite window)
//   i_rom_data              texel colour, ROM_LATENCY cycles after o_rom_addr
//   o_rgb, o_on             pixel colour and opaque/visible flag
//   o_busy, o_done          sliding / parked-and-animating
module sprite_anim_display #(
    parameter int          WIDTH       = 280,
    parameter int          HEIGHT      = 320,
    parameter int          SCALE_SHIFT = 1,
    parameter int          FRAMES      = 2,
    parameter int          FRAME_TICKS = 8,
    parameter int          START_X     = 180,
    parameter int          START_Y     = 480,
    parameter int          END_Y       = 80,
    parameter int          STEP        = 8,
    parameter logic [11:0] TRANSPARENT = 12'h3b9,
    parameter int          ROM_LATENCY = 1,
    parameter int          ADDR_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_xg,
    input  logic [9:0]        i_yg,
    input  logic              i_frame_tick,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [11:0]       i_rom_data,
    output logic [11:0]       o_rgb,
    output logic              o_on,
    output logic              o_busy,
    output logic              o_done
);

    localparam int SW          = WIDTH >> SCALE_SHIFT;
    localparam int SH          = HEIGHT >> SCALE_SHIFT;
    localparam int FRAME_WORDS = SW * SH;
    localparam int FIDX_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TICK_W      = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SLIDE = 2'd1;
    localparam logic [1:0] S_ANIM  = 2'd2;

    // Window bounds are kept in 11 bits so START+SIZE-1 never wraps.
    localparam logic [10:0] X_LO    = 11'(START_X);
    localparam logic [10:0] X_HI    = 11'(START_X + WIDTH - 1);
    localparam logic [10:0] Y_START = 11'(START_Y);
    localparam logic [10:0] Y_END   = 11'(END_Y);
    localparam logic [10:0] STEP_V  = 11'(STEP);
    localparam logic [10:0] H_M1    = 11'(HEIGHT - 1);
    // "top - STEP <= END_Y" rewritten as "top <= END_Y + STEP" to avoid underflow.
    localparam logic [11:0] SLIDE_LAST = 12'(END_Y + STEP);

    logic [1:0]          r_state;
    logic [10:0]         r_top;
    logic [FIDX_W-1:0]   r_frame_idx;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ROM_LATENCY:0] r_hit_pipe;

    logic [10:0]       w_x;
    logic [10:0]       w_y;
    logic [10:0]       w_y_hi;
    logic              w_hit;
    logic [10:0]       w_x_rom;
    logic [10:0]       w_y_rom;
    logic [ADDR_W-1:0] w_addr;
    logic              w_slide_done;
    logic              w_tick_wrap;
    logic              w_last_frame;
    logic              w_aligned_hit;

    assign w_x    = {1'b0, i_xg};
    assign w_y    = {1'b0, i_yg};
    assign w_y_hi = r_top + H_M1;
    assign w_hit  = (w_x >= X_LO) && (w_x <= X_HI) && (w_y >= r_top) && (w_y <= w_y_hi);

    // Offsets are only meaningful when w_hit is set; the address is forced to 0 otherwise.
    assign w_x_rom = (w_x - X_LO) >> SCALE_SHIFT;
    assign w_y_rom = (w_y - r_top) >> SCALE_SHIFT;
    assign w_addr  = ADDR_W'(r_frame_idx) * ADDR_W'(FRAME_WORDS)
                   + ADDR_W'(w_y_rom) * ADDR_W'(SW)
                   + ADDR_W'(w_x_rom);

    assign w_slide_done = ({1'b0, r_top} <= SLIDE_LAST);
    assign w_tick_wrap  = (r_tick_cnt == TICK_W'(FRAME_TICKS - 1));
    assign w_last_frame = (r_frame_idx == FIDX_W'(FRAMES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_top       <= Y_START;
            r_frame_idx <= '0;
            r_tick_cnt  <= '0;
            r_rom_addr  <= '0;
            r_hit_pipe  <= '0;
        end else begin
            r_rom_addr <= w_hit ? w_addr : '0;
            // Visibility is judged with the state seen by the pixel, then delayed to meet rom_data.
            r_hit_pipe <= {r_hit_pipe[ROM_LATENCY-1:0], w_hit && (r_state != S_IDLE)};

            if (i_start) begin
                // start overrides any frame_tick in the same cycle
                r_state     <= S_SLIDE;
                r_top       <= Y_START;
                r_frame_idx <= '0;
                r_tick_cnt  <= '0;
            end else if (i_frame_tick) begin
                case (r_state)
                    S_SLIDE: begin
                        if (w_slide_done) begin
                            r_top   <= Y_END;
                            r_state <= S_ANIM;
                        end else begin
                            r_top <= r_top - STEP_V;
                        end
                    end
                    S_ANIM: begin
                        if (w_tick_wrap) begin
                            r_tick_cnt  <= '0;
                            r_frame_idx <= w_last_frame ? '0 : r_frame_idx + 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign w_aligned_hit = r_hit_pipe[ROM_LATENCY];

    assign o_rom_addr = r_rom_addr;
    assign o_on       = w_aligned_hit && (i_rom_data != TRANSPARENT);
    assign o_rgb      = o_on ? i_rom_data : 12'h000;
    assign o_busy     = (r_state == S_SLIDE);
    assign o_done     = (r_state == S_ANIM);

endmodule

// File: tb/tb_sprite_anim_display.sv
module tb_sprite_anim_display;

    localparam int W   = 280;
    localparam int H   = 320;
    localparam int S   = 1;
    localparam int SW  = W >> S;
    localparam int SH  = H >> S;
    localparam int NF  = 2;
    localparam int FT  = 8;
    localparam int SX  = 180;
    localparam int SY  = 480;
    localparam int EY  = 80;
    localparam int STP = 8;
    localparam logic [11:0] TR = 12'h3b9;

    logic        clk = 1'b0;
    logic        rst, frame_tick, start;
    logic [9:0]  xg, yg;
    logic [15:0] rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [11:0] rgb;
    logic        on, busy, done;

    int checks = 0;
    int failures = 0;

    sprite_anim_display dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_xg        (xg),
        .i_yg        (yg),
        .i_frame_tick(frame_tick),
        .i_start     (start),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_rgb       (rgb),
        .o_on        (on),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: address 2 is pure red, every third word is the colour key.
    function automatic logic [11:0] rom_f(input int a);
        if (a == 2)          return 12'hf00;
        else if (a % 3 == 0) return TR;
        else                 return 12'((a * 157 + 1) & 12'hfff);
    endfunction

    always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

    // ---------------- behavioural model ----------------
    // Position and frame are derived from the number of frame_ticks since the last start.
    bit m_ok = 0;
    bit m_active = 0;
    int m_ticks = 0;
    bit m_hv0 = 0, m_hv1 = 0;
    int m_ad0 = 0, m_ad1 = 0;

    function automatic int n_slide();
        if (SY == EY) return 1;
        return (SY - EY + STP - 1) / STP;
    endfunction

    function automatic int m_top();
        if (!m_active || m_ticks == 0) return SY;
        if (m_ticks < n_slide()) return SY - m_ticks * STP;
        return EY;
    endfunction

    function automatic int m_frame();
        if (!m_active || m_ticks < n_slide()) return 0;
        return ((m_ticks - n_slide()) / FT) % NF;
    endfunction

    always @(posedge clk) begin : model
        int top, fr, x, y;
        bit hit;
        if (rst) begin
            m_ok = 1; m_active = 0; m_ticks = 0;
            m_hv0 = 0; m_hv1 = 0; m_ad0 = 0; m_ad1 = 0;
        end else begin
            top = m_top(); fr = m_frame();
            x = int'(xg); y = int'(yg);
            hit = (x >= SX) && (x <= SX + W - 1) && (y >= top) && (y <= top + H - 1);
            m_hv1 = m_hv0; m_ad1 = m_ad0;
            m_hv0 = hit && m_active;
            m_ad0 = hit ? fr * SW * SH + ((y - top) >> S) * SW + ((x - SX) >> S) : 0;
            if (start) begin
                m_active = 1; m_ticks = 0;
            end else if (m_active && frame_tick) begin
                m_ticks++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit e_on;
        logic [11:0] e_rgb;
        if (m_ok) begin
            e_on  = m_hv1 && (rom_f(m_ad1) != TR);
            e_rgb = e_on ? rom_f(m_ad1) : 12'h000;
            chk("model_rom_addr", 32'(rom_addr), 32'(m_ad0));
            chk("model_on", 32'(on), 32'(e_on));
            chk("model_rgb", 32'(rgb), 32'(e_rgb));
            chk("model_busy", 32'(busy), 32'(m_active && m_ticks < n_slide()));
            chk("model_done", 32'(done), 32'(m_active && m_ticks >= n_slide()));
        end
    end

    // Drive one cycle's inputs, let the edge happen, return at the following negedge.
    task automatic step(input int x, input int y, input bit t, input bit s, input bit r);
        xg = 10'(x); yg = 10'(y); frame_tick = t; start = s; rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int x, y;
        rst = 1; start = 0; frame_tick = 0; xg = 0; yg = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_on", 32'(on), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);

        // Idle: sprite hidden even on its own origin pixel
        repeat (3) step(180, 480, 0, 0, 0);
        chk("idle_on", 32'(on), 0);
        chk("idle_rgb", 32'(rgb), 0);
        chk("idle_busy", 32'(busy), 0);

        // Slide-in: 49 ticks still sliding, top now 88
        step(0, 0, 0, 1, 0);
        chk("start_busy", 32'(busy), 1);
        repeat (49) step(0, 0, 1, 0, 0);
        chk("tick49_busy", 32'(busy), 1);
        chk("tick49_done", 32'(done), 0);
        step(180, 90, 0, 0, 0);
        chk("top88_addr", 32'(rom_addr), 140);
        step(0, 0, 1, 0, 0);
        chk("tick50_busy", 32'(busy), 0);
        chk("tick50_done", 32'(done), 1);

        // Parked at top=80, frame 0
        step(180, 80, 0, 0, 0);
        chk("origin_addr", 32'(rom_addr), 0);
        step(184, 80, 0, 0, 0);
        chk("texel2_addr", 32'(rom_addr), 2);
        chk("key_on", 32'(on), 0);
        chk("key_rgb", 32'(rgb), 0);
        step(459, 399, 0, 0, 0);
        chk("corner_addr", 32'(rom_addr), 22399);
        chk("red_on", 32'(on), 1);
        chk("red_rgb", 32'(rgb), 12'hf00);
        step(460, 80, 0, 0, 0);
        chk("xout_addr", 32'(rom_addr), 0);
        step(180, 400, 0, 0, 0);
        chk("xout_on", 32'(on), 0);
        step(0, 0, 0, 0, 0);
        chk("yout_on", 32'(on), 0);

        // Animation frames
        repeat (8) step(0, 0, 1, 0, 0);
        step(180, 80, 0, 0, 0);
        chk("frame1_addr", 32'(rom_addr), 22400);
        repeat (8) step(0, 0, 1, 0, 0);
        step(180, 80, 0, 0, 0);
        chk("frame0_wrap_addr", 32'(rom_addr), 0);

        // start with a same-cycle tick: tick is dropped, top back to 480
        step(0, 0, 1, 1, 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_done", 32'(done), 0);
        step(180, 482, 0, 0, 0);
        chk("restart_top_addr", 32'(rom_addr), 140);

        // Reset mid-slide, with a start that must be ignored
        repeat (3) step(0, 0, 1, 0, 0);
        step(200, 470, 0, 1, 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_addr", 32'(rom_addr), 0);
        chk("abort_on", 32'(on), 0);
        step(0, 0, 0, 0, 0);
        chk("abort_start_ignored", 32'(busy), 0);

        // Randomised run against the model
        for (int i = 0; i < 30000; i++) begin
            case ($urandom_range(0, 5))
                0: x = 179;
                1: x = 180;
                2: x = 459;
                3: x = 460;
                default: x = $urandom_range(160, 480);
            endcase
            if ($urandom_range(0, 9) == 0) y = $urandom_range(0, 1023);
            else y = $urandom_range(60, 820);
            step(x, y, $urandom_range(0, 3) == 0, $urandom_range(0, 1999) == 0,
                 $urandom_range(0, 4999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
